// File: rtl/cmac_sched_pkg.sv
// Shared definitions for the cmac accumulator scheduler.
//   sched_state_e : sequencer states
//   win_len()     : serial window length in cycles for a given log2 size
package cmac_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun,
    StFlush
  } sched_state_e;

  localparam int unsigned DEF_SERIAL_ACC_LEN_BITS = 7;

  function automatic int unsigned win_len(input int unsigned bits);
    return 32'd1 << bits;
  endfunction

endpackage

// File: rtl/sched_pulse_delay.sv
// Fixed-latency delay line for the accumulator-shift pulse and the window tag it carries.
//   clk, rst_n    : clock, asynchronous active-low clear
//   in_pulse/tag  : pulse and tag entering the line
//   out_pulse/tag : same pulse/tag DEPTH cycles later
//   any_pulse     : a pulse is somewhere in the line (including the output stage)
module sched_pulse_delay #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TAG_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_pulse,
  input  logic [TAG_BITS-1:0] in_tag,
  output logic                out_pulse,
  output logic [TAG_BITS-1:0] out_tag,
  output logic                any_pulse
);

  logic [DEPTH-1:0]    pulse_q;
  logic [TAG_BITS-1:0] tag_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      pulse_q[0] <= in_pulse;
      tag_q[0]   <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        pulse_q[i] <= pulse_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign out_pulse = pulse_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];
  assign any_pulse = |pulse_q;

endmodule

// File: rtl/cmac_acc_sched.sv
// Sequencer for a chain of cmac taps.
//   en, sync_in, data_valid : scheduling enable, upstream integration sync, sample-stream valid
//   sync_out, valid_inj     : sync to every tap, accumulator-shift pulse into the chain head
//   chain_valid             : valid_out of the tail tap
//   rd_valid/tap/last/win   : tagged readout of the tail results (registered)
//   busy                    : not idle
//   err_gap, err_valid      : sticky sequencing errors
module cmac_acc_sched
  import cmac_sched_pkg::*;
#(
  parameter int unsigned SERIAL_ACC_LEN_BITS = DEF_SERIAL_ACC_LEN_BITS,
  parameter int unsigned N_TAPS              = 8,
  parameter int unsigned TAP_BITS            = 3,
  parameter int unsigned CHAIN_LATENCY       = 16,
  parameter int unsigned WIN_CNT_BITS        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    sync_in,
  input  logic                    data_valid,
  output logic                    sync_out,
  output logic                    valid_inj,
  input  logic                    chain_valid,
  output logic                    rd_valid,
  output logic [TAP_BITS-1:0]     rd_tap,
  output logic                    rd_last,
  output logic [WIN_CNT_BITS-1:0] rd_win,
  output logic                    busy,
  output logic                    err_gap,
  output logic                    err_valid
);

  localparam int unsigned WIN_LEN = win_len(SERIAL_ACC_LEN_BITS);
  localparam logic [TAP_BITS-1:0] LAST_TAP = TAP_BITS'(N_TAPS - 1);

  if (N_TAPS < 1 || N_TAPS > WIN_LEN || CHAIN_LATENCY < 1) begin : g_bad_params
    $error("cmac_acc_sched: need 1 <= N_TAPS <= 2^SERIAL_ACC_LEN_BITS and CHAIN_LATENCY >= 1");
  end

  sched_state_e state_q, state_d;

  logic                           sync_out_q;
  logic [SERIAL_ACC_LEN_BITS-1:0] wc_q;
  logic [WIN_CNT_BITS-1:0]        win_q;
  logic                           first_q;
  logic                           slot_act_q;
  logic [TAP_BITS-1:0]            tap_q;
  logic [WIN_CNT_BITS-1:0]        slot_tag_q;
  logic                           rd_valid_q, rd_last_q;
  logic [TAP_BITS-1:0]            rd_tap_q;
  logic [WIN_CNT_BITS-1:0]        rd_win_q;
  logic                           err_gap_q, err_valid_q;

  logic                    go_run, gap, err_clr, flush_done;
  logic                    dly_pulse, dly_any;
  logic [WIN_CNT_BITS-1:0] dly_tag;
  logic                    in_slot, rd_hit;
  logic [TAP_BITS-1:0]     cur_tap;
  logic [WIN_CNT_BITS-1:0] cur_tag;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StArm;
      StArm: begin
        if (!en)                          state_d = StIdle;
        else if (sync_in && data_valid)   state_d = StRun;
      end
      StRun: begin
        if (!data_valid) state_d = StArm;
        else if (!en)    state_d = StFlush;
      end
      StFlush: if (flush_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    go_run    = 1'b0;
    gap       = 1'b0;
    err_clr   = 1'b0;
    valid_inj = 1'b0;
    unique case (state_q)
      StIdle: err_clr = en;
      StArm:  go_run  = en && sync_in && data_valid;
      StRun: begin
        gap    = !data_valid;
        go_run = data_valid && en && sync_in;
        // First window after a sync has no complete result yet.
        valid_inj = data_valid && (wc_q == '0) && !first_q && !sync_out_q;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign flush_done = !dly_any && !slot_act_q;

  // ---------------- window counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_out_q <= 1'b0;
      wc_q       <= '0;
      win_q      <= '0;
      first_q    <= 1'b0;
    end else begin
      sync_out_q <= go_run;
      if (sync_out_q) begin
        wc_q    <= '0;
        win_q   <= '0;
        first_q <= 1'b1;
      end else begin
        wc_q <= wc_q + 1'b1;
        if (wc_q == '1) begin
          win_q   <= win_q + 1'b1;
          first_q <= 1'b0;
        end
      end
    end
  end

  assign sync_out = sync_out_q;

  // ---------------- expected-slot tracking ----------------
  sched_pulse_delay #(
    .DEPTH    (CHAIN_LATENCY),
    .TAG_BITS (WIN_CNT_BITS)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pulse  (valid_inj),
    .in_tag    (win_q - 1'b1),
    .out_pulse (dly_pulse),
    .out_tag   (dly_tag),
    .any_pulse (dly_any)
  );

  // A delayed pulse arriving on the cycle after a slot ends starts a contiguous slot.
  assign in_slot = dly_pulse || slot_act_q;
  assign cur_tap = dly_pulse ? '0 : tap_q;
  assign cur_tag = dly_pulse ? dly_tag : slot_tag_q;
  assign rd_hit  = in_slot && chain_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_act_q  <= 1'b0;
      tap_q       <= '0;
      slot_tag_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_tap_q    <= '0;
      rd_win_q    <= '0;
      rd_last_q   <= 1'b0;
      err_gap_q   <= 1'b0;
      err_valid_q <= 1'b0;
    end else begin
      if (in_slot) begin
        slot_act_q <= (cur_tap != LAST_TAP);
        tap_q      <= cur_tap + 1'b1;
        slot_tag_q <= cur_tag;
      end
      rd_valid_q <= rd_hit;
      rd_tap_q   <= rd_hit ? cur_tap : '0;
      rd_win_q   <= rd_hit ? cur_tag : '0;
      rd_last_q  <= rd_hit && (cur_tap == LAST_TAP);
      if (err_clr) begin
        err_gap_q   <= 1'b0;
        err_valid_q <= 1'b0;
      end else begin
        if (gap)                    err_gap_q   <= 1'b1;
        if (chain_valid != in_slot) err_valid_q <= 1'b1;
      end
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_tap    = rd_tap_q;
  assign rd_win    = rd_win_q;
  assign rd_last   = rd_last_q;
  assign err_gap   = err_gap_q;
  assign err_valid = err_valid_q;

endmodule

// File: tb/tb_cmac_acc_sched.sv
module tb_cmac_acc_sched;

  localparam int S       = 3;
  localparam int WIN_LEN = 8;
  localparam int N_TAPS  = 4;
  localparam int LAT     = 5;
  localparam int WB      = 2;
  localparam int TB      = 2;

  localparam int M_IDLE  = 0;
  localparam int M_ARM   = 1;
  localparam int M_RUN   = 2;
  localparam int M_FLUSH = 3;

  logic          clk, rst_n, en, sync_in, data_valid, chain_valid;
  logic          sync_out, valid_inj, rd_valid, rd_last, busy, err_gap, err_valid;
  logic [TB-1:0] rd_tap;
  logic [WB-1:0] rd_win;

  cmac_acc_sched #(
    .SERIAL_ACC_LEN_BITS (S),
    .N_TAPS              (N_TAPS),
    .TAP_BITS            (TB),
    .CHAIN_LATENCY       (LAT),
    .WIN_CNT_BITS        (WB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sync_in     (sync_in),
    .data_valid  (data_valid),
    .sync_out    (sync_out),
    .valid_inj   (valid_inj),
    .chain_valid (chain_valid),
    .rd_valid    (rd_valid),
    .rd_tap      (rd_tap),
    .rd_last     (rd_last),
    .rd_win      (rd_win),
    .busy        (busy),
    .err_gap     (err_gap),
    .err_valid   (err_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert, n_fail;
  int cyc;

  // Reference model: mode, age since the last sync_out pulse, and the list of expected slots.
  int mode;
  bit m_sync;
  int m_age;
  int slot_start[$];
  int slot_tag[$];
  bit e_rd_valid, e_rd_last, e_gap, e_verr;
  int e_rd_tap, e_rd_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, req);
    end
  endtask

  task automatic model_clear();
    mode = M_IDLE;
    m_sync = 1'b0;
    m_age = -1;
    slot_start.delete();
    slot_tag.delete();
    e_rd_valid = 1'b0;
    e_rd_last = 1'b0;
    e_gap = 1'b0;
    e_verr = 1'b0;
    e_rd_tap = 0;
    e_rd_win = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    sync_in = 1'b0;
    data_valid = 1'b0;
    chain_valid = 1'b0;
    #1;
    chk("rst_sync_out", sync_out, 0);
    chk("rst_valid_inj", valid_inj, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_tap", rd_tap, 0);
    chk("rst_rd_win", rd_win, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_gap", err_gap, 0);
    chk("rst_err_valid", err_valid, 0);
    model_clear();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc += 2;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  // chain_valid follows an ideal tap chain (high exactly in expected slots) unless flip is set.
  task automatic step(input bit e, input bit s, input bit d, input bit flip);
    bit ins, vinj, acc, clr, hit;
    int tap, tag, vtag, nmode;
    while (slot_start.size() > 0 && slot_start[0] + N_TAPS <= cyc) begin
      void'(slot_start.pop_front());
      void'(slot_tag.pop_front());
    end
    ins = 1'b0;
    tap = 0;
    tag = 0;
    foreach (slot_start[i]) begin
      if (slot_start[i] <= cyc && cyc < slot_start[i] + N_TAPS) begin
        ins = 1'b1;
        tap = cyc - slot_start[i];
        tag = slot_tag[i];
      end
    end
    en = e;
    sync_in = s;
    data_valid = d;
    chain_valid = ins ^ flip;
    #1;
    // Inject at the start of every window after the first one following sync_out.
    vinj = (mode == M_RUN) && d && (m_age > WIN_LEN) && (((m_age - 1) % WIN_LEN) == 0);
    vtag = (((m_age - 1) / WIN_LEN) - 1) % (1 << WB);
    chk("sync_out", sync_out, m_sync);
    chk("valid_inj", valid_inj, vinj);
    chk("busy", busy, mode != M_IDLE);
    chk("rd_valid", rd_valid, e_rd_valid);
    chk("rd_tap", rd_tap, e_rd_tap);
    chk("rd_win", rd_win, e_rd_win);
    chk("rd_last", rd_last, e_rd_last);
    chk("err_gap", err_gap, e_gap);
    chk("err_valid", err_valid, e_verr);

    acc = (mode == M_ARM || mode == M_RUN) && e && d && s;
    clr = (mode == M_IDLE) && e;
    nmode = mode;
    case (mode)
      M_IDLE: if (e) nmode = M_ARM;
      M_ARM: begin
        if (!e) nmode = M_IDLE;
        else if (s && d) nmode = M_RUN;
      end
      M_RUN: begin
        if (!d) nmode = M_ARM;
        else if (!e) nmode = M_FLUSH;
      end
      default: if (slot_start.size() == 0) nmode = M_IDLE;
    endcase
    hit = ins && !flip;
    e_rd_valid = hit;
    e_rd_tap = hit ? tap : 0;
    e_rd_win = hit ? tag : 0;
    e_rd_last = hit && (tap == N_TAPS - 1);
    e_verr = clr ? 1'b0 : (e_verr | flip);
    e_gap = clr ? 1'b0 : (e_gap | ((mode == M_RUN) && !d));
    if (vinj) begin
      slot_start.push_back(cyc + LAT);
      slot_tag.push_back(vtag);
    end
    m_sync = acc;
    m_age = acc ? 0 : ((m_age >= 0) ? m_age + 1 : -1);
    mode = nmode;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int t;
    n_assert = 0;
    n_fail = 0;
    cyc = 0;
    model_clear();
    rst_n = 1'b1;
    en = 1'b0;
    sync_in = 1'b0;
    data_valid = 1'b0;
    chain_valid = 1'b0;
    #2;
    do_reset();

    // Nominal run with a stray chain_valid two cycles after the first slot ends.
    repeat (2) step(0, 0, 0, 0);
    repeat ($urandom_range(1, 4)) step(1, 0, 1, 0);
    t = cyc;
    while (cyc < t + 32) step(1, cyc == t, 1, cyc == t + 20);
    repeat (24) step(0, 0, 1, 0);

    // Re-arm clears errors; short burst (last tap missing), then a one-cycle gap.
    repeat ($urandom_range(1, 3)) step(1, 0, 1, 0);
    t = cyc;
    while (cyc < t + 26) step(1, cyc == t, 1, cyc == t + 18);
    step(1, 0, 0, 0);
    repeat (20) step(1, 0, 1, 0);

    // Restart, resync at wc=5 of window 2, then long enough for the window tag to wrap.
    t = cyc;
    while (cyc < t + 95) step(1, (cyc == t) || (cyc == t + 23), 1, 0);

    // Shutdown while a slot is in progress.
    repeat (14) step(0, 0, 1, 0);

    // Reset in the middle of a readout.
    repeat (2) step(1, 0, 1, 0);
    t = cyc;
    while (cyc < t + 17) step(1, cyc == t, 1, 0);
    do_reset();
    repeat (10) step(0, 0, 0, 0);

    // Randomised traffic.
    repeat (400) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 59) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
